// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : RV32I decode stage with valid/ready handshake, 2-entry skid
//            buffer, flush and immediate generation. Optional illegal-insn
//            check under macro DECODE_ILLEGAL_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic [AWIDTH-1:0] pc_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        shamt_o,
  output logic [6:0]        funct7_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic              illegal_o
);

  localparam logic [DWIDTH-1:0] c_nop = {{(DWIDTH-7){1'b0}}, 7'h13};

  localparam logic [6:0] c_op_lui    = 7'h37;
  localparam logic [6:0] c_op_auipc  = 7'h17;
  localparam logic [6:0] c_op_jal    = 7'h6F;
  localparam logic [6:0] c_op_jalr   = 7'h67;
  localparam logic [6:0] c_op_branch = 7'h63;
  localparam logic [6:0] c_op_load   = 7'h03;
  localparam logic [6:0] c_op_store  = 7'h23;
  localparam logic [6:0] c_op_opimm  = 7'h13;

  generate
    if (DWIDTH != 32) begin : g_bad_dwidth
      $error("decode_stage: only DWIDTH = 32 is supported");
    end
  endgenerate

  logic              r_main_valid;
  logic [AWIDTH-1:0] r_main_pc;
  logic [DWIDTH-1:0] r_main_insn;

  logic              w_skid_valid;
  logic [AWIDTH-1:0] w_skid_pc;
  logic [DWIDTH-1:0] w_skid_insn;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_main_load;

  assign valid_o     = r_main_valid;
  assign w_in_xfer   = valid_i & ready_o;
  assign w_out_xfer  = r_main_valid & ready_i;
  assign w_main_load = ~r_main_valid | w_out_xfer;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic              r_skid_valid;
      logic [AWIDTH-1:0] r_skid_pc;
      logic [DWIDTH-1:0] r_skid_insn;

      // The skid refills from the input only in the same cycle it hands its
      // entry to main, so ordering stays strictly FIFO.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_skid_valid <= 1'b0;
          r_skid_pc    <= '0;
          r_skid_insn  <= c_nop;
        end else if (flush_i) begin
          r_skid_valid <= 1'b0;
        end else if (w_main_load) begin
          if (r_skid_valid) begin
            if (w_in_xfer) begin
              r_skid_pc   <= pc_i;
              r_skid_insn <= insn_i;
            end else begin
              r_skid_valid <= 1'b0;
            end
          end
        end else if (w_in_xfer) begin
          r_skid_valid <= 1'b1;
          r_skid_pc    <= pc_i;
          r_skid_insn  <= insn_i;
        end
      end

      assign w_skid_valid = r_skid_valid;
      assign w_skid_pc    = r_skid_pc;
      assign w_skid_insn  = r_skid_insn;
      assign ready_o      = ~r_skid_valid;
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_pc    = '0;
      assign w_skid_insn  = c_nop;
      assign ready_o      = ready_i | ~r_main_valid;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_insn  <= c_nop;
    end else if (flush_i) begin
      r_main_valid <= 1'b0;
      r_main_insn  <= c_nop;
    end else if (w_main_load) begin
      if (w_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_pc    <= w_skid_pc;
        r_main_insn  <= w_skid_insn;
      end else if (w_in_xfer) begin
        r_main_valid <= 1'b1;
        r_main_pc    <= pc_i;
        r_main_insn  <= insn_i;
      end else begin
        r_main_valid <= 1'b0;
      end
    end
  end

  assign pc_o     = r_main_pc;
  assign insn_o   = r_main_insn;
  assign opcode_o = r_main_insn[6:0];
  assign rd_o     = r_main_insn[11:7];
  assign funct3_o = r_main_insn[14:12];
  assign rs1_o    = r_main_insn[19:15];
  assign rs2_o    = r_main_insn[24:20];
  assign shamt_o  = r_main_insn[24:20];
  assign funct7_o = r_main_insn[31:25];

  logic [31:0] w_imm;

  always_comb begin
    w_imm = 32'h0;
    case (r_main_insn[6:0])
      c_op_opimm, c_op_load, c_op_jalr:
        w_imm = {{20{r_main_insn[31]}}, r_main_insn[31:20]};
      c_op_store:
        w_imm = {{20{r_main_insn[31]}}, r_main_insn[31:25], r_main_insn[11:7]};
      c_op_branch:
        w_imm = {{19{r_main_insn[31]}}, r_main_insn[31], r_main_insn[7],
                 r_main_insn[30:25], r_main_insn[11:8], 1'b0};
      c_op_lui, c_op_auipc:
        w_imm = {r_main_insn[31:12], 12'h000};
      c_op_jal:
        w_imm = {{11{r_main_insn[31]}}, r_main_insn[31], r_main_insn[19:12],
                 r_main_insn[20], r_main_insn[30:21], 1'b0};
      default:
        w_imm = 32'h0;
    endcase
  end

  assign imm_o = w_imm;

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic w_bad;

  always_comb begin
    w_bad = 1'b0;
    if (r_main_insn[1:0] != 2'b11) w_bad = 1'b1;
    case (r_main_insn[6:0])
      c_op_lui, c_op_auipc, c_op_jal, c_op_jalr, 7'h0F, 7'h73: ;
      7'h33:
        if (r_main_insn[31:25] != 7'h00 && r_main_insn[31:25] != 7'h20) w_bad = 1'b1;
      c_op_opimm:
        if ((r_main_insn[14:12] == 3'b001 || r_main_insn[14:12] == 3'b101) &&
            r_main_insn[31:25] != 7'h00 && r_main_insn[31:25] != 7'h20) w_bad = 1'b1;
      c_op_load:
        if (r_main_insn[14:12] == 3'b011 || r_main_insn[14:12] == 3'b110 ||
            r_main_insn[14:12] == 3'b111) w_bad = 1'b1;
      c_op_store:
        if (r_main_insn[14:12] > 3'b010) w_bad = 1'b1;
      c_op_branch:
        if (r_main_insn[14:12] == 3'b010 || r_main_insn[14:12] == 3'b011) w_bad = 1'b1;
      default:
        w_bad = 1'b1;
    endcase
  end

  assign illegal_o = r_main_valid & w_bad;
`else
  assign illegal_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Directed + randomized bench for decode_stage against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] insn_i = '0;
  logic [31:0] pc_i = '0;
  logic        ready_o, valid_o, illegal_o;
  logic [31:0] pc_o, insn_o, imm_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o, shamt_o;
  logic [2:0]  funct3_o;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .insn_i(insn_i), .pc_i(pc_i), .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .rd_o(rd_o),
    .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .shamt_o(shamt_o),
    .funct7_o(funct7_o), .imm_o(imm_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: the stage is a 2-deep FIFO; the head (or last head) is displayed.
  logic [31:0] q_insn[$];
  logic [31:0] q_pc[$];
  logic [31:0] hold_pc;
  logic [31:0] hold_insn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] r;
    r = 0;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: begin i12 = w[31:20]; r = i12; end
      7'h23: begin i12 = {w[31:25], w[11:7]}; r = i12; end
      7'h63: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; r = b13; end
      7'h37, 7'h17: r = w & 32'hFFFF_F000;
      7'h6F: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; r = j21; end
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] w, input logic v);
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic bad;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    bad = !(op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73});
    bad = bad || (w[1:0] != 2'b11);
    if (op == 7'h33 && !(f7 inside {7'h00, 7'h20})) bad = 1'b1;
    if (op == 7'h13 && (f3 inside {3'd1, 3'd5}) && !(f7 inside {7'h00, 7'h20})) bad = 1'b1;
    if (op == 7'h03 && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) bad = 1'b1;
    if (op == 7'h23 && !(f3 inside {3'd0, 3'd1, 3'd2})) bad = 1'b1;
    if (op == 7'h63 && (f3 inside {3'd2, 3'd3})) bad = 1'b1;
    return v && bad;
`else
    return 1'b0 & v & w[0];
`endif
  endfunction

  task automatic check_all();
    logic m_valid;
    m_valid = (q_insn.size() > 0);
    chk("valid_o",   {31'b0, valid_o},   {31'b0, m_valid});
    chk("ready_o",   {31'b0, ready_o},   {31'b0, q_insn.size() < 2});
    chk("pc_o",      pc_o,               hold_pc);
    chk("insn_o",    insn_o,             hold_insn);
    chk("opcode_o",  {25'b0, opcode_o},  {25'b0, hold_insn[6:0]});
    chk("rd_o",      {27'b0, rd_o},      {27'b0, hold_insn[11:7]});
    chk("funct3_o",  {29'b0, funct3_o},  {29'b0, hold_insn[14:12]});
    chk("rs1_o",     {27'b0, rs1_o},     {27'b0, hold_insn[19:15]});
    chk("rs2_o",     {27'b0, rs2_o},     {27'b0, hold_insn[24:20]});
    chk("shamt_o",   {27'b0, shamt_o},   {27'b0, hold_insn[24:20]});
    chk("funct7_o",  {25'b0, funct7_o},  {25'b0, hold_insn[31:25]});
    chk("imm_o",     imm_o,              ref_imm(hold_insn));
    chk("illegal_o", {31'b0, illegal_o}, {31'b0, ref_illegal(hold_insn, m_valid)});
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    logic in_x, out_x;
    valid_i = v; insn_i = ins; pc_i = pc; ready_i = rdy; flush_i = fl;
    in_x  = v && (q_insn.size() < 2);
    out_x = rdy && (q_insn.size() > 0);
    @(posedge clk);
    #1;
    if (fl) begin
      q_insn.delete(); q_pc.delete();
      hold_insn = c_nop;
    end else begin
      if (out_x) begin void'(q_insn.pop_front()); void'(q_pc.pop_front()); end
      if (in_x) begin q_insn.push_back(ins); q_pc.push_back(pc); end
    end
    if (q_insn.size() > 0) begin hold_insn = q_insn[0]; hold_pc = q_pc[0]; end
    check_all();
  endtask

  function automatic logic [31:0] rand_insn();
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 13);
    if (k < 11) w[6:0] = ops[k];
    return w;
  endfunction

  initial begin
    hold_pc = '0;
    hold_insn = c_nop;

    // Reset baseline, sampled while reset is still asserted
    #12;
    check_all();
    chk("rst_imm", imm_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("nop_insn", insn_o, c_nop);

    // Streaming
    step(1'b1, 32'hFFF0_0093, 32'h100, 1'b1, 1'b0);
    chk("addi_rd", {27'b0, rd_o}, 32'd1);
    chk("addi_imm", imm_o, 32'hFFFF_FFFF);
    chk("addi_pc", pc_o, 32'h100);
    step(1'b1, 32'h0020_0113, 32'h104, 1'b1, 1'b0);
    chk("b2b_pc1", pc_o, 32'h104);
    step(1'b1, 32'h0030_0193, 32'h108, 1'b1, 1'b0);
    chk("b2b_pc2", pc_o, 32'h108);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure A, B, C
    step(1'b1, 32'h00A0_0513, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h0140_0593, 32'h204, 1'b0, 1'b0);
    chk("bp_full_ready", {31'b0, ready_o}, 32'd0);
    step(1'b1, 32'h01E0_0613, 32'h208, 1'b0, 1'b0);
    chk("bp_hold_a", insn_o, 32'h00A0_0513);
    step(1'b1, 32'h01E0_0613, 32'h208, 1'b1, 1'b0);
    chk("bp_out_b", insn_o, 32'h0140_0593);
    step(1'b1, 32'h01E0_0613, 32'h208, 1'b1, 1'b0);
    chk("bp_out_c", insn_o, 32'h01E0_0613);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_drained", {31'b0, valid_o}, 32'd0);

    // Immediate formats
    step(1'b1, 32'hFE11_2E23, 32'h300, 1'b1, 1'b0);
    chk("imm_sw", imm_o, 32'hFFFF_FFFC);
    step(1'b1, 32'hFE00_0EE3, 32'h304, 1'b1, 1'b0);
    chk("imm_beq", imm_o, 32'hFFFF_FFFC);
    step(1'b1, 32'h0080_00EF, 32'h308, 1'b1, 1'b0);
    chk("imm_jal", imm_o, 32'h0000_0008);
    step(1'b1, 32'h1234_52B7, 32'h30C, 1'b1, 1'b0);
    chk("imm_lui", imm_o, 32'h1234_5000);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with both entries full plus a valid input
    step(1'b1, 32'h0010_0093, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0093, 32'h404, 1'b0, 1'b0);
    step(1'b1, 32'h0030_0093, 32'h408, 1'b1, 1'b1);
    chk("flush_valid", {31'b0, valid_o}, 32'd0);
    chk("flush_ready", {31'b0, ready_o}, 32'd1);
    chk("flush_nop", insn_o, c_nop);
    chk("flush_pc", pc_o, 32'h400);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Illegal detection
    step(1'b1, 32'h0000_007F, 32'h500, 1'b1, 1'b0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    chk("ill_opcode", {31'b0, illegal_o}, 32'd1);
`else
    chk("ill_opcode", {31'b0, illegal_o}, 32'd0);
`endif
    step(1'b1, 32'h0200_0033, 32'h504, 1'b1, 1'b0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    chk("ill_funct7", {31'b0, illegal_o}, 32'd1);
`else
    chk("ill_funct7", {31'b0, illegal_o}, 32'd0);
`endif
    step(1'b1, c_nop, 32'h508, 1'b1, 1'b0);
    chk("ill_nop", {31'b0, illegal_o}, 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stall, checked before the next clock edge
    step(1'b1, 32'h0040_0093, 32'h600, 1'b0, 1'b0);
    step(1'b1, 32'h0050_0093, 32'h604, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, valid_o}, 32'd0);
    chk("arst_ready", {31'b0, ready_o}, 32'd1);
    chk("arst_insn", insn_o, c_nop);
    chk("arst_pc", pc_o, 32'h0);
    q_insn.delete(); q_pc.delete();
    hold_pc = '0; hold_insn = c_nop;
    @(posedge clk); #1;
    rst = 1'b1;
    check_all();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, rand_insn(), $urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
